iob_dma_mc: RTL and testbench

Multi-channel AXI-Stream-to-AXI-write DMA engine: the parametrised successor of the single-stream DMA, serving N_CH independent stream inputs concurrently instead of one muxed interface. Each channel is programmed with a word-aligned base address and a word length, then drained into memory via INCR bursts on one shared AXI write master. Bursts are split at BURST_MAX and at 4 KB boundaries, and channels are granted round-robin per burst. It sits between stream producers and the system interconnect; the CSR block drives its config port.

---
 rtl/iob_dma_mc_pkg.sv | 7 +
 rtl/iob_dma_mc_rr_arb.sv | 32 +++
 rtl/iob_dma_mc.sv | 158 +++++++++++++++
 tb/tb_iob_dma_mc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_dma_mc_pkg.sv
// iob_dma_mc_pkg: shared FSM encoding and AXI constants for the multi-channel DMA
package iob_dma_mc_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_AW, ST_W, ST_B} state_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int BOUNDARY_4K = 4096;
endpackage

// File: rtl/iob_dma_mc_rr_arb.sv
// iob_dma_mc_rr_arb: round-robin arbiter, searches from the channel after the last grant
module iob_dma_mc_rr_arb
    import iob_dma_mc_pkg::*;
#(
    parameter int N = 2,
    parameter int SEL_W = 1
) (
    input  logic             clk,
    input  logic             cke,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             upd,
    output logic [SEL_W-1:0] grant
);
    logic [SEL_W-1:0] ptr;
    logic found;
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                grant = SEL_W'((int'(ptr) + i) % N);
            end
        end
    end
    // pointer starts at the last channel so channel 0 wins first
    always_ff @(posedge clk) begin
        if (rst) ptr <= SEL_W'(N - 1);
        else if (cke && upd && found) ptr <= grant;
    end
endmodule

// File: rtl/iob_dma_mc.sv
// iob_dma_mc: multi-channel AXI-Stream to AXI-write DMA with round-robin burst arbitration
module iob_dma_mc
    import iob_dma_mc_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W = 16,
    parameter int BURST_MAX = 16,
    parameter logic [ADDR_W-1:0] MEM_ADDR_OFFSET = '0,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic [SEL_W-1:0]         cfg_ch_i,
    input  logic [ADDR_W-1:0]        cfg_addr_i,
    input  logic [LEN_W-1:0]         cfg_len_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          done_o,
    output logic [N_CH-1:0]          err_o,
    input  logic [N_CH*DATA_W-1:0]   tdata_i,
    input  logic [N_CH-1:0]          tvalid_i,
    output logic [N_CH-1:0]          tready_o,
    output logic [ADDR_W-1:0]        awaddr_o,
    output logic [7:0]               awlen_o,
    output logic [2:0]               awsize_o,
    output logic [1:0]               awburst_o,
    output logic                     awvalid_o,
    input  logic                     awready_i,
    output logic [DATA_W-1:0]        wdata_o,
    output logic [DATA_W/8-1:0]      wstrb_o,
    output logic                     wlast_o,
    output logic                     wvalid_o,
    input  logic                     wready_i,
    input  logic [1:0]               bresp_i,
    input  logic                     bvalid_i,
    output logic                     bready_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ = $clog2(BYTES);

    state_t state, state_nx;
    logic [ADDR_W-1:0] addr [N_CH];
    logic [LEN_W-1:0] rem [N_CH];
    logic [N_CH-1:0] busy, done, err, busy_nx, done_nx, err_nx;
    logic [SEL_W-1:0] g, arb_idx;
    logic [8:0] blen, blen_c;
    logic [7:0] cnt;
    logic [12:0] to_4k;
    logic [31:0] words, lim;
    logic cfg_fire, w_fire, b_fire, last_beat;

    iob_dma_mc_rr_arb #(.N(N_CH), .SEL_W(SEL_W)) u_arb (
        .clk(clk_i),
        .cke(cke_i),
        .rst(rst_i),
        .req(busy),
        .upd(state == ST_ARB),
        .grant(arb_idx)
    );

    assign cfg_ready_o = (32'(cfg_ch_i) < N_CH) && !busy[cfg_ch_i];
    assign cfg_fire = cfg_valid_i && cfg_ready_o;
    assign w_fire = (state == ST_W) && tvalid_i[g] && wready_i;
    assign b_fire = (state == ST_B) && bvalid_i;
    assign last_beat = {1'b0, cnt} == blen - 9'd1;

    // burst length: smallest of remaining words, BURST_MAX and words left in the 4 KB page
    assign to_4k = 13'(BOUNDARY_4K) - {1'b0, addr[arb_idx][11:0]};
    assign words = 32'(to_4k >> SZ);
    assign lim = (32'(rem[arb_idx]) < 32'(BURST_MAX)) ? 32'(rem[arb_idx]) : 32'(BURST_MAX);
    assign blen_c = 9'((lim < words) ? lim : words);

    always_comb begin
        busy_nx = busy;
        done_nx = done;
        err_nx = err;
        if (b_fire) begin
            err_nx[g] = err[g] | (bresp_i != AXI_RESP_OKAY);
            if (rem[g] == LEN_W'(blen)) begin
                busy_nx[g] = 1'b0;
                done_nx[g] = 1'b1;
            end
        end
        if (cfg_fire) begin
            busy_nx[cfg_ch_i] = cfg_len_i != '0;
            done_nx[cfg_ch_i] = cfg_len_i == '0;
            err_nx[cfg_ch_i] = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = |busy_nx ? ST_ARB : ST_IDLE;
            ST_ARB:  state_nx = ST_AW;
            ST_AW:   state_nx = awready_i ? ST_W : ST_AW;
            ST_W:    state_nx = (w_fire && last_beat) ? ST_B : ST_W;
            ST_B:    state_nx = !bvalid_i ? ST_B : |busy_nx ? ST_ARB : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            g <= '0;
            blen <= '0;
            cnt <= '0;
            busy <= '0;
            done <= '0;
            err <= '0;
            for (int c = 0; c < N_CH; c++) begin
                addr[c] <= '0;
                rem[c] <= '0;
            end
        end else if (cke_i) begin
            state <= state_nx;
            busy <= busy_nx;
            done <= done_nx;
            err <= err_nx;
            if (state == ST_ARB) begin
                g <= arb_idx;
                blen <= blen_c;
                cnt <= '0;
            end else if (w_fire) begin
                cnt <= cnt + 8'd1;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_fire && 32'(cfg_ch_i) == c) begin
                    addr[c] <= cfg_addr_i & ~ADDR_W'(BYTES - 1);
                    rem[c] <= cfg_len_i;
                end else if (b_fire && 32'(g) == c) begin
                    addr[c] <= addr[c] + (ADDR_W'(blen) << SZ);
                    rem[c] <= rem[c] - LEN_W'(blen);
                end
            end
        end
    end

    assign busy_o = busy;
    assign done_o = done;
    assign err_o = err;
    assign awvalid_o = state == ST_AW;
    assign awaddr_o = awvalid_o ? addr[g] + MEM_ADDR_OFFSET : '0;
    assign awlen_o = awvalid_o ? 8'(blen - 9'd1) : '0;
    assign awsize_o = awvalid_o ? 3'(SZ) : '0;
    assign awburst_o = awvalid_o ? AXI_BURST_INCR : '0;
    assign wvalid_o = (state == ST_W) && tvalid_i[g];
    assign wdata_o = (state == ST_W) ? tdata_i[int'(g) * DATA_W +: DATA_W] : '0;
    assign wstrb_o = (state == ST_W) ? '1 : '0;
    assign wlast_o = (state == ST_W) && last_beat;
    assign bready_o = state == ST_B;
    assign tready_o = (state == ST_W && wready_i) ? (N_CH'(1) << g) : '0;
endmodule

// File: tb/tb_iob_dma_mc.sv
// tb_iob_dma_mc: randomized AXI slave and stream producers checked against a burst-list model
module tb_iob_dma_mc;
    typedef struct {logic [31:0] addr; int beats; int ch;} burst_t;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst_i = 1, cke_i = 1;
    logic cfg_ch_i = 0, cfg_valid_i = 0, cfg_ready_o;
    logic [31:0] cfg_addr_i = 0;
    logic [15:0] cfg_len_i = 0;
    logic [1:0] busy_o, done_o, err_o, tready_o;
    logic [1:0] tvalid_i = 0;
    logic [63:0] tdata_i = 0;
    logic [31:0] awaddr_o, wdata_o;
    logic [7:0] awlen_o;
    logic [2:0] awsize_o;
    logic [1:0] awburst_o, bresp_i = 0;
    logic [3:0] wstrb_o;
    logic awvalid_o, awready_i = 0, wlast_o, wvalid_o, wready_i = 0, bvalid_i = 0, bready_o;

    iob_dma_mc dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .cfg_ch_i(cfg_ch_i), .cfg_addr_i(cfg_addr_i), .cfg_len_i(cfg_len_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_o(tready_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    int n_chk = 0, n_pass = 0;
    burst_t exp_q[$];
    logic [31:0] tx_q [2][$];
    logic [31:0] sent [2][$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] base [2];
    int len_c [2];
    logic [31:0] w_addr = 0;
    int w_left = 0, burst_idx = 0, err_at = -1, beats_seen = 0, aw_seen = 0;
    logic b_pending = 0;
    logic [1:0] exp_err = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // slave and producers: drive at negedge, account handshakes for the coming posedge
    initial begin
        forever begin
            @(negedge clk);
            awready_i = $urandom_range(0, 3) != 0;
            wready_i = $urandom_range(0, 3) != 0;
            bvalid_i = b_pending && $urandom_range(0, 2) != 0;
            bresp_i = (burst_idx == err_at) ? 2'b10 : 2'b00;
            for (int c = 0; c < 2; c++) begin
                tvalid_i[c] = tx_q[c].size() > 0 && $urandom_range(0, 3) != 0;
                tdata_i[c*32 +: 32] = tx_q[c].size() > 0 ? tx_q[c][0] : $urandom;
            end
            #1;
            if (rst_i) begin
                exp_q.delete();
                tx_q[0].delete();
                tx_q[1].delete();
                w_left = 0;
                b_pending = 0;
            end else begin
                for (int c = 0; c < 2; c++)
                    if (tvalid_i[c] && tready_o[c]) void'(tx_q[c].pop_front());
                if (awvalid_o && awready_i) begin
                    aw_seen++;
                    chk("aw_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        chk("aw_addr", awaddr_o, exp_q[0].addr);
                        chk("aw_len", awlen_o, exp_q[0].beats - 1);
                        chk("aw_size", awsize_o, 2);
                        chk("aw_burst", awburst_o, 1);
                        w_addr = awaddr_o;
                        w_left = int'(awlen_o) + 1;
                        void'(exp_q.pop_front());
                    end
                end
                if (wvalid_o && wready_i) begin
                    chk("wlast", wlast_o, w_left == 1);
                    chk("wstrb", wstrb_o, 4'hF);
                    mem[w_addr] = wdata_o;
                    w_addr += 4;
                    w_left--;
                    beats_seen++;
                    if (w_left == 0) b_pending = 1;
                end
                if (bvalid_i && bready_o) begin
                    b_pending = 0;
                    burst_idx++;
                end
            end
        end
    end

    // reference: split each channel into bursts, then interleave them round-robin
    task automatic start(logic [31:0] a0, int l0, logic [31:0] a1, int l1, int e);
        burst_t cq [2][$];
        logic [31:0] a [2];
        int l [2];
        int last, b, room, c;
        a[0] = a0 & ~32'd3;
        a[1] = a1 & ~32'd3;
        l[0] = l0;
        l[1] = l1;
        mem.delete();
        exp_q.delete();
        burst_idx = 0;
        err_at = e;
        exp_err = 0;
        for (int k = 0; k < 2; k++) begin
            base[k] = a[k];
            len_c[k] = l[k];
            sent[k].delete();
            tx_q[k].delete();
            for (int i = 0; i < l[k]; i++) begin
                logic [31:0] v = $urandom;
                sent[k].push_back(v);
                tx_q[k].push_back(v);
            end
            while (l[k] > 0) begin
                room = (4096 - int'(a[k][11:0])) / 4;
                b = l[k] < 16 ? l[k] : 16;
                b = b < room ? b : room;
                cq[k].push_back('{a[k], b, k});
                a[k] += 32'(4 * b);
                l[k] -= b;
            end
        end
        last = 1;
        while (cq[0].size() + cq[1].size() > 0) begin
            c = cq[(last + 1) % 2].size() > 0 ? (last + 1) % 2 : last;
            exp_q.push_back(cq[c].pop_front());
            last = c;
        end
        if (e >= 0 && e < exp_q.size()) exp_err[exp_q[e].ch] = 1'b1;
    endtask

    task automatic cfg(int ch, logic [31:0] a, int l);
        @(negedge clk);
        cfg_valid_i = 1;
        cfg_ch_i = ch[0];
        cfg_addr_i = a;
        cfg_len_i = 16'(l);
        #1 chk("cfg_ready", cfg_ready_o, 1);
        @(negedge clk);
        cfg_valid_i = 0;
    endtask

    task automatic finish(logic [1:0] mask);
        int t = 0;
        while ((busy_o & mask) != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("timeout", t < 5000, 1);
        chk("done", done_o & mask, mask);
        chk("err", err_o & mask, exp_err & mask);
        chk("bursts_left", exp_q.size(), 0);
        for (int c = 0; c < 2; c++)
            if (mask[c])
                for (int i = 0; i < len_c[c]; i++) begin
                    logic [31:0] k = base[c] + 32'(4 * i);
                    chk("mem", mem.exists(k) ? mem[k] : 32'hx, sent[c][i]);
                end
    endtask

    initial begin
        int n, t, b0;
        logic [31:0] a0, a1;
        int l0, l1, e;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_awvalid", awvalid_o, 0);
        chk("rst_wvalid", wvalid_o, 0);
        chk("rst_bready", bready_o, 0);
        chk("rst_tready", tready_o, 0);
        chk("rst_cfg_ready", cfg_ready_o, 1);
        rst_i = 0;

        start(32'h1000, 40, 0, 0, -1);
        cfg(0, 32'h1000, 40);
        finish(2'b01);
        chk("busy0_clear", busy_o[0], 0);

        start(32'h5000, 40, 0, 0, 1);
        cfg(0, 32'h5000, 40);
        finish(2'b01);

        start(32'h0FF8, 6, 0, 0, -1);
        cfg(0, 32'h0FF8, 6);
        chk("done_cleared", done_o[0], 0);
        chk("err_cleared", err_o[0], 0);
        finish(2'b01);

        start(32'h4000, 32, 32'h4100, 32, -1);
        cfg(0, 32'h4000, 32);
        cfg(1, 32'h4100, 32);
        finish(2'b11);

        start(0, 0, 32'h6000, 0, -1);
        n = aw_seen;
        cfg(1, 32'h6000, 0);
        chk("len0_done", done_o[1], 1);
        chk("len0_busy", busy_o[1], 0);
        repeat (5) @(negedge clk);
        chk("len0_no_aw", aw_seen, n);

        start(32'h2000, 40, 0, 0, -1);
        cfg(0, 32'h2000, 40);
        b0 = beats_seen;
        t = 0;
        while (beats_seen < b0 + 5 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("midw_timeout", t < 2000, 1);
        rst_i = 1;
        @(negedge clk);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_awvalid", awvalid_o, 0);
        chk("mrst_wvalid", wvalid_o, 0);
        chk("mrst_wlast", wlast_o, 0);
        chk("mrst_bready", bready_o, 0);
        chk("mrst_tready", tready_o, 0);
        rst_i = 0;
        start(32'h3000, 20, 0, 0, -1);
        cfg(0, 32'h3000, 20);
        chk("t1_busy", busy_o[0], 1);
        chk("t1_awvalid", awvalid_o, 0);
        @(negedge clk);
        chk("t2_awvalid", awvalid_o, 1);
        finish(2'b01);

        for (int i = 0; i < 6; i++) begin
            a0 = 32'h10000 * (i + 1) + 32'h1000 - 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
            a1 = 32'h10000 * (i + 1) + 32'h8000 - 32'(4 * $urandom_range(0, 40));
            l0 = $urandom_range(0, 50);
            l1 = $urandom_range(0, 50);
            e = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 4)) : -1;
            start(a0, l0, a1, l1, e);
            cfg(0, a0, l0);
            cfg(1, a1, l1);
            finish(2'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
